eco_cone_sweep_ctrl: RTL and testbench
======================================

Name: eco_cone_sweep_ctrl

Overview:
Controller that exhaustively sequences every operand pair into two 5-in/5-in/3-out gate-level cones, the original netlist and its ECO-revised copy, sharing one stimulus bus. It compares their outputs and counts mismatches. It records the first failing vector and reports pass/fail. It sits in the ECO equivalence bench/BIST wrapper, driving both cones from registered outputs.

Parameters:
W_A, 5, width of operand A
W_B, 5, width of operand B
W_Y, 3, width of cone output Y
SAMPLE_LAT, 1, cycles from stimulus change to valid Y at this block's inputs; legal 0..4
STOP_ON_FAIL, 0, 1 = end sweep after first mismatch

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin sweep; sampled in IDLE or DONE only
abort  in  1  cancel sweep, return to IDLE
a_o  out  W_A  operand A to both cones (registered)
b_o  out  W_B  operand B to both cones (registered)
y_ref_i  in  W_Y  original cone output
y_rev_i  in  W_Y  revised cone output
busy  out  1  high in SWEEP/DRAIN
done  out  1  level; high in DONE until next start/abort
pass  out  1  done && mismatch_cnt==0
mismatch_cnt  out  W_A+W_B+1  mismatching vector count
ff_valid  out  1  first-fail record valid
ff_a  out  W_A  A of first failing vector
ff_b  out  W_B  B of first failing vector
ff_ref  out  W_Y  y_ref_i captured at first failure
ff_rev  out  W_Y  y_rev_i captured at first failure

Behaviour:
- Reset (async, rst_n=0): state IDLE; a_o=b_o=0; busy=done=pass=0; mismatch_cnt=0; ff_*=0.
- Vector index idx is W_A+W_B bits. a_o=idx[W_A+W_B-1:W_B], b_o=idx[W_B-1:0]. Order: 0 to 2^(W_A+W_B)-1, so 1024 vectors by default.
- FSM IDLE -> SWEEP on start. Entry clears mismatch_cnt and ff_*.
- Vector i appears on a_o/b_o in cycle i+1 after the start edge, so one vector is issued per cycle.
- Each issued vector pushes {idx, valid} into a delay pipe of depth SAMPLE_LAT. Compare happens at the edge where the tag emerges: edge i+2+SAMPLE_LAT relative to the start edge. With SAMPLE_LAT=0, compare uses the current a_o/b_o cycle.
- Mismatch is y_ref_i != y_rev_i on a valid tag. It increments mismatch_cnt. If ff_valid=0, it also captures ff_a/ff_b from the tag, ff_ref/ff_rev from the inputs, and sets ff_valid.
- SWEEP -> DRAIN after issuing the last vector, or, if STOP_ON_FAIL=1, on the first mismatch. Issue stops immediately. In-flight tags are still compared and may add to mismatch_cnt.
- DRAIN -> DONE when the pipe holds no valid tags; this is immediate when SAMPLE_LAT=0. Full sweep: done rises after edge 1025+SAMPLE_LAT (default 1026).
- DONE: done=1, busy=0, a_o/b_o=0. Results are held. start -> SWEEP (clear and rerun).
- start while busy: ignored.
- abort (any state, priority over start): next state IDLE. Pipe is flushed, a_o/b_o=0, done=0. mismatch_cnt/ff_* cleared.
- Reset asserted mid-sweep: immediate return to reset values with no partial results.
- mismatch_cnt width holds 2^(W_A+W_B) and never wraps.

Decomposition:
- Package eco_chk_pkg holds:
  - state enum {IDLE, SWEEP, DRAIN, DONE}
  - NUM_VEC = 2^(W_A+W_B) and IDX_W constants
  - tag struct {idx, valid}
- Sub-module eco_tag_pipe is a parameterised SAMPLE_LAT-deep shift register of tags with flush input and any_valid output; depth 0 is a pass-through.

Test Plan:
1. Cones identical (rev=ref), SAMPLE_LAT=1, start pulse -> busy for the sweep, done after edge 1026, pass=1, mismatch_cnt=0, ff_valid=0.
2. Rev differs from ref only at A=3,B=0 (bit 1 flipped) -> mismatch_cnt=1, ff_a=3, ff_b=0, ff_rev=ff_ref^3'b010, pass=0.
3. Rev differs from ref whenever A[4]=1 -> mismatch_cnt=512, ff_a=16, ff_b=0.
4. Test 3 case with STOP_ON_FAIL=1, SAMPLE_LAT=2 -> idx 512 is the first compared mismatch. Issue stops, and the two in-flight vectors are still compared, so mismatch_cnt=3. ff_a=16, ff_b=0, and done rises well before 1024 cycles.
5. abort asserted while a_o=3,b_o=4 (idx 100) -> next cycle IDLE, busy=0, done=0, mismatch_cnt=0; a subsequent start performs a full clean sweep.
6. start pulsed during SWEEP, and rst_n pulsed low mid-sweep -> start has no effect; reset clears all outputs asynchronously; a fresh start after reset runs to pass=1.

Source files
------------

// File: rtl/eco_chk_pkg.sv
// -----------------------------------------------------------------------------
// eco_chk_pkg
// Shared types and constants for the ECO cone-equivalence sweep controller.
//   A_W / B_W / Y_W : default operand and cone-output widths
//   IDX_W           : width of the flattened vector index {A, B}
//   NUM_VEC         : number of vectors in one exhaustive sweep
//   state_t         : controller FSM states
//   tag_t           : {idx, valid} token that travels alongside the cone latency
// -----------------------------------------------------------------------------
package eco_chk_pkg;

  localparam int A_W     = 5;
  localparam int B_W     = 5;
  localparam int Y_W     = 3;
  localparam int IDX_W   = A_W + B_W;
  localparam int NUM_VEC = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             valid;
  } tag_t;

endpackage

// File: rtl/eco_tag_pipe.sv
// -----------------------------------------------------------------------------
// eco_tag_pipe
// DEPTH-deep shift register of vector tags that mirrors the cone latency, so a
// tag leaves the pipe in the same cycle the matching cone outputs are valid.
// DEPTH = 0 is a plain pass-through.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush_i      : synchronously invalidates every stage
//   tag_i        : tag of the vector currently on the stimulus bus
//   tag_o        : tag whose cone result is valid this cycle
//   any_valid_o  : a valid tag will still be awaiting comparison after the
//                  next edge (tag_i or any stage other than the output stage)
// -----------------------------------------------------------------------------
module eco_tag_pipe
  import eco_chk_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic any_valid_o
);

  if (DEPTH == 0) begin : g_bypass

    assign tag_o       = tag_i;
    // The tag on the bus is compared in this very cycle, so nothing remains
    // in flight afterwards.
    assign any_valid_o = 1'b0;

  end else begin : g_shift

    tag_t stage_q [DEPTH];
    logic any_v;

    // NOTE: every stage is reset because the valid bits are control state; a
    // stale valid tag after reset would be counted as a real comparison.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (flush_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= tag_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    // The output stage is consumed at the coming edge; everything upstream
    // of it (including the tag being pushed now) is still in flight.
    always_comb begin
      any_v = tag_i.valid;
      for (int i = 0; i < DEPTH - 1; i++) any_v = any_v | stage_q[i].valid;
    end

    assign tag_o       = stage_q[DEPTH-1];
    assign any_valid_o = any_v;

  end

endmodule

// File: rtl/eco_cone_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// eco_cone_sweep_ctrl
// Exhaustively drives every {A,B} operand pair into the original and the
// ECO-revised cone, compares their outputs after SAMPLE_LAT cycles, counts
// mismatching vectors and records the first failing vector.
// Operand widths follow eco_chk_pkg; W_A/W_B/W_Y must match the package.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin a sweep (accepted only in IDLE or DONE)
//   abort           : cancel and clear everything, return to IDLE (beats start)
//   a_o, b_o        : registered stimulus to both cones
//   y_ref_i/y_rev_i : original / revised cone outputs
//   busy            : sweep issuing or draining
//   done, pass      : sweep finished; pass when no mismatch was seen
//   mismatch_cnt    : number of mismatching vectors
//   ff_valid, ff_a, ff_b, ff_ref, ff_rev : first-failure record
// -----------------------------------------------------------------------------
module eco_cone_sweep_ctrl
  import eco_chk_pkg::*;
#(
  parameter int W_A          = A_W,
  parameter int W_B          = B_W,
  parameter int W_Y          = Y_W,
  parameter int SAMPLE_LAT   = 1,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [W_A-1:0]       a_o,
  output logic [W_B-1:0]       b_o,
  input  logic [W_Y-1:0]       y_ref_i,
  input  logic [W_Y-1:0]       y_rev_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [W_A+W_B:0]     mismatch_cnt,
  output logic                 ff_valid,
  output logic [W_A-1:0]       ff_a,
  output logic [W_B-1:0]       ff_b,
  output logic [W_Y-1:0]       ff_ref,
  output logic [W_Y-1:0]       ff_rev
);

  // One extra bit so the count can reach NUM_VEC without wrapping.
  localparam int CNT_W = W_A + W_B + 1;

  state_t           state_q;
  logic [IDX_W-1:0] issue_idx_q;   // next vector to put on the bus
  logic [IDX_W-1:0] cur_idx_q;     // vector currently on the bus
  logic             issue_vld_q;   // bus carries a real vector
  logic             busy_q, done_q, pass_q;
  logic [CNT_W-1:0] mis_cnt_q;
  logic             ff_valid_q;
  logic [W_A-1:0]   ff_a_q;
  logic [W_B-1:0]   ff_b_q;
  logic [W_Y-1:0]   ff_ref_q, ff_rev_q;

  tag_t tag_in, tag_out;
  logic in_flight;
  logic mis;

  assign tag_in = '{idx: cur_idx_q, valid: issue_vld_q};

  eco_tag_pipe #(
    .DEPTH (SAMPLE_LAT)
  ) u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (abort),
    .tag_i       (tag_in),
    .tag_o       (tag_out),
    .any_valid_o (in_flight)
  );

  assign mis = tag_out.valid && (y_ref_i != y_rev_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      issue_idx_q <= '0;
      cur_idx_q   <= '0;
      issue_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      mis_cnt_q   <= '0;
      ff_valid_q  <= 1'b0;
      ff_a_q      <= '0;
      ff_b_q      <= '0;
      ff_ref_q    <= '0;
      ff_rev_q    <= '0;
    end else if (abort) begin
      state_q     <= IDLE;
      issue_idx_q <= '0;
      cur_idx_q   <= '0;
      issue_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      mis_cnt_q   <= '0;
      ff_valid_q  <= 1'b0;
      ff_a_q      <= '0;
      ff_b_q      <= '0;
      ff_ref_q    <= '0;
      ff_rev_q    <= '0;
    end else begin
      // Compare the tag emerging from the pipe against this cycle's outputs.
      if (mis) begin
        mis_cnt_q <= mis_cnt_q + CNT_W'(1);
        if (!ff_valid_q) begin
          ff_valid_q <= 1'b1;
          ff_a_q     <= tag_out.idx[IDX_W-1 -: W_A];
          ff_b_q     <= tag_out.idx[W_B-1:0];
          ff_ref_q   <= y_ref_i;
          ff_rev_q   <= y_rev_i;
        end
      end

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            // These clears are written after the compare above so they take
            // precedence; no tag is ever valid in IDLE/DONE anyway.
            state_q     <= SWEEP;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            issue_idx_q <= '0;
            mis_cnt_q   <= '0;
            ff_valid_q  <= 1'b0;
            ff_a_q      <= '0;
            ff_b_q      <= '0;
            ff_ref_q    <= '0;
            ff_rev_q    <= '0;
          end
        end

        SWEEP: begin
          if ((STOP_ON_FAIL != 0) && mis) begin
            // Stop issuing at once; tags already in the pipe still drain.
            state_q     <= DRAIN;
            cur_idx_q   <= '0;
            issue_vld_q <= 1'b0;
          end else begin
            cur_idx_q   <= issue_idx_q;
            issue_vld_q <= 1'b1;
            issue_idx_q <= issue_idx_q + IDX_W'(1);
            if (issue_idx_q == IDX_W'(NUM_VEC - 1)) state_q <= DRAIN;
          end
        end

        DRAIN: begin
          cur_idx_q   <= '0;
          issue_vld_q <= 1'b0;
          if (!in_flight) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // Include a mismatch on the final tag compared at this same edge.
            pass_q  <= (mis_cnt_q == '0) && !mis;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_o          = cur_idx_q[IDX_W-1 -: W_A];
  assign b_o          = cur_idx_q[W_B-1:0];
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mis_cnt_q;
  assign ff_valid     = ff_valid_q;
  assign ff_a         = ff_a_q;
  assign ff_b         = ff_b_q;
  assign ff_ref       = ff_ref_q;
  assign ff_rev       = ff_rev_q;

endmodule

// File: tb/tb_eco_cone_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_eco_cone_sweep_ctrl
// Directed bench: two controllers (SAMPLE_LAT=1/STOP_ON_FAIL=0 and
// SAMPLE_LAT=2/STOP_ON_FAIL=1), each feeding a behavioural reference cone and
// a revised cone with a selectable injected error, delayed by SAMPLE_LAT.
// -----------------------------------------------------------------------------
module tb_eco_cone_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, start_sf, abort_sf;

  logic [4:0]  a_o, b_o, a_sf, b_sf;
  logic [2:0]  y_ref, y_rev, y_ref_sf, y_rev_sf;
  logic        busy, done, pass, ff_valid;
  logic        busy_sf, done_sf, pass_sf, ff_valid_sf;
  logic [10:0] mis_cnt, mis_cnt_sf;
  logic [4:0]  ff_a, ff_b, ff_a_sf, ff_b_sf;
  logic [2:0]  ff_ref, ff_rev, ff_ref_sf, ff_rev_sf;

  int n_tests = 0;
  int n_fail  = 0;
  int mode    = 0;   // 0: identical cones, 1: error at A=3,B=0, 2: error when A[4]
  int e;

  eco_cone_sweep_ctrl #(.SAMPLE_LAT(1), .STOP_ON_FAIL(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_o(a_o), .b_o(b_o), .y_ref_i(y_ref), .y_rev_i(y_rev),
    .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mis_cnt),
    .ff_valid(ff_valid), .ff_a(ff_a), .ff_b(ff_b), .ff_ref(ff_ref), .ff_rev(ff_rev)
  );

  eco_cone_sweep_ctrl #(.SAMPLE_LAT(2), .STOP_ON_FAIL(1)) dut_sf (
    .clk(clk), .rst_n(rst_n), .start(start_sf), .abort(abort_sf),
    .a_o(a_sf), .b_o(b_sf), .y_ref_i(y_ref_sf), .y_rev_i(y_rev_sf),
    .busy(busy_sf), .done(done_sf), .pass(pass_sf), .mismatch_cnt(mis_cnt_sf),
    .ff_valid(ff_valid_sf), .ff_a(ff_a_sf), .ff_b(ff_b_sf), .ff_ref(ff_ref_sf),
    .ff_rev(ff_rev_sf)
  );

  function automatic logic [2:0] cone_f(input logic [4:0] a, input logic [4:0] b);
    return (a[2:0] + b[2:0]) ^ {b[4], a[3], a[4]};
  endfunction

  function automatic logic [2:0] err_f(input int m, input logic [4:0] a, input logic [4:0] b);
    if (m == 1) return (a == 5'd3 && b == 5'd0) ? 3'b010 : 3'b000;
    if (m == 2) return a[4] ? 3'b001 : 3'b000;
    return 3'b000;
  endfunction

  // Cone models: one register stage for the first controller, two for the second.
  logic [2:0] s1_ref, s1_rev;
  always @(posedge clk) begin
    y_ref    <= cone_f(a_o, b_o);
    y_rev    <= cone_f(a_o, b_o) ^ err_f(mode, a_o, b_o);
    s1_ref   <= cone_f(a_sf, b_sf);
    s1_rev   <= cone_f(a_sf, b_sf) ^ err_f(mode, a_sf, b_sf);
    y_ref_sf <= s1_ref;
    y_rev_sf <= s1_rev;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Called on a falling edge; returns just after the start edge (edge 0).
  task automatic pulse_start(input bit sf);
    if (sf) start_sf = 1'b1; else start = 1'b1;
    tick(1);
    start_sf = 1'b0;
    start    = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen, bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 3000) begin
      tick(1);
      edges++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_sf = 1'b0; abort_sf = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_pass",  pass, 0);
    check("rst_cnt",   mis_cnt, 0);
    check("rst_ffv",   ff_valid, 0);
    check("rst_ab",    {a_o, b_o}, 0);
    check("rst_sf",    {busy_sf, done_sf, ff_valid_sf, mis_cnt_sf}, 0);
    rst_n = 1'b1;
    tick(1);

    // 1: identical cones, exact done timing
    mode = 0;
    pulse_start(0);
    check("t1_busy0",  busy, 1);
    tick(1);
    check("t1_vec0",   {a_o, b_o}, 0);
    tick(1024);
    check("t1_done1025", done, 0);
    check("t1_busy1025", busy, 1);
    tick(1);
    check("t1_done1026", done, 1);
    check("t1_busy",   busy, 0);
    check("t1_pass",   pass, 1);
    check("t1_cnt",    mis_cnt, 0);
    check("t1_ffv",    ff_valid, 0);
    check("t1_ab",     {a_o, b_o}, 0);

    // 2: single mismatch at A=3,B=0 (restart from DONE)
    mode = 1;
    pulse_start(0);
    wait_done(e);
    check("t2_edge",   e, 1026);
    check("t2_cnt",    mis_cnt, 1);
    check("t2_ffv",    ff_valid, 1);
    check("t2_ffa",    ff_a, 3);
    check("t2_ffb",    ff_b, 0);
    check("t2_ffref",  ff_ref, cone_f(5'd3, 5'd0));
    check("t2_ffrev",  ff_rev, cone_f(5'd3, 5'd0) ^ 3'b010);
    check("t2_pass",   pass, 0);

    // 3: mismatch whenever A[4]=1
    mode = 2;
    pulse_start(0);
    wait_done(e);
    check("t3_edge",   e, 1026);
    check("t3_cnt",    mis_cnt, 512);
    check("t3_ffa",    ff_a, 16);
    check("t3_ffb",    ff_b, 0);
    check("t3_ffrev",  ff_rev, cone_f(5'd16, 5'd0) ^ 3'b001);
    check("t3_pass",   pass, 0);

    // 4: stop-on-fail, SAMPLE_LAT=2: idx 512 compared at edge 516, two
    //    in-flight tags drain, done at edge 518
    pulse_start(1);
    tick(517);
    check("t4_done517", done_sf, 0);
    check("t4_busy517", busy_sf, 1);
    tick(1);
    check("t4_done518", done_sf, 1);
    check("t4_cnt",    mis_cnt_sf, 3);
    check("t4_ffa",    ff_a_sf, 16);
    check("t4_ffb",    ff_b_sf, 0);
    check("t4_ffref",  ff_ref_sf, cone_f(5'd16, 5'd0));
    check("t4_pass",   pass_sf, 0);
    check("t4_ab",     {a_sf, b_sf}, 0);

    // 5: abort at idx 100 after one mismatch has been recorded
    mode = 1;
    pulse_start(0);
    tick(101);
    check("t5_a",      a_o, 3);
    check("t5_b",      b_o, 4);
    check("t5_precnt", mis_cnt, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t5_busy",   busy, 0);
    check("t5_done",   done, 0);
    check("t5_cnt",    mis_cnt, 0);
    check("t5_ffv",    ff_valid, 0);
    check("t5_ab",     {a_o, b_o}, 0);
    mode = 0;
    pulse_start(0);
    wait_done(e);
    check("t5_edge",   e, 1026);
    check("t5_pass",   pass, 1);
    check("t5_cnt2",   mis_cnt, 0);

    // 6: start during sweep is ignored; async reset mid-sweep clears all
    mode = 1;
    pulse_start(0);
    tick(50);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    check("t6_vec51",  {a_o, b_o}, 51);
    check("t6_busy",   busy, 1);
    tick(60);
    check("t6_precnt", mis_cnt, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rbusy",  busy, 0);
    check("t6_rcnt",   mis_cnt, 0);
    check("t6_rffv",   ff_valid, 0);
    check("t6_rab",    {a_o, b_o}, 0);
    tick(1);
    rst_n = 1'b1;
    mode = 0;
    tick(1);
    pulse_start(0);
    wait_done(e);
    check("t6_edge",   e, 1026);
    check("t6_pass",   pass, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
